adder_share_arb: RTL and testbench

//   Shares one registered adder datapath (sum = x + y + cin) among NUM_REQ requesters.

---
 rtl/adder_share_arb.sv | 146 ++++++++++++++
 tb/tb_adder_share_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define ADDER_SHARE_ARB_STATS_EN to add op_cnt/grant_cnt statistics outputs.
module adder_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SWIDTH = WIDTH + 1,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [SWIDTH-1:0]        rsp_sum,
  output logic                     rsp_zero
`ifdef ADDER_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]              op_cnt,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              vld_q, vld_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [SWIDTH-1:0] sum_q, sum_d;
  logic              zero_q, zero_d;

  logic [IDW-1:0]    gnt_id;
  logic              found;
  logic              accept;
  logic [WIDTH-1:0]  x_g, y_g;
  logic [SWIDTH-1:0] sum_new;
  int                idx;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  assign accept = (state_q == IDLE) && found;
  assign x_g = req_x[int'(gnt_id)*WIDTH +: WIDTH];
  assign y_g = req_y[int'(gnt_id)*WIDTH +: WIDTH];
  assign sum_new = SWIDTH'(x_g) + SWIDTH'(y_g)
                 + SWIDTH'(req_cin[gnt_id]);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    vld_d     = vld_q;
    id_d      = id_q;
    sum_d     = sum_q;
    zero_d    = zero_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready[gnt_id] = 1'b1;
          sum_d   = sum_new;
          zero_d  = (sum_new == '0);
          id_d    = gnt_id;
          vld_d   = 1'b1;
          state_d = RESP;
          if (gnt_id == IDW'(NUM_REQ - 1)) rr_ptr_d = '0;
          else rr_ptr_d = gnt_id + IDW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      sum_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_zero  = zero_q;

`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [15:0] op_cnt_q;
  logic [15:0] gcnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else if (accept) begin
      if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      if (gcnt_q[gnt_id] != 16'hFFFF)
        gcnt_q[gnt_id] <= gcnt_q[gnt_id] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = gcnt_q[i];
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb with randomized requesters.
// Reference model tracks pending requests, round-robin pointer and busy phase.
module tb_adder_share_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 9;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_x, req_y;
  logic rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [S-1:0] rsp_sum;
  logic rsp_zero;
`ifdef ADDER_SHARE_ARB_STATS_EN
  logic [15:0] op_cnt;
  logic [N*16-1:0] grant_cnt;
`endif

  adder_share_arb #(.NUM_REQ(N), .WIDTH(W), .SWIDTH(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_zero(rsp_zero)
`ifdef ADDER_SHARE_ARB_STATS_EN
    , .op_cnt(op_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [S-1:0]   sum;
    logic           zero;
  } rsp_t;

  rsp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  int ptr = 0;
  bit busy = 0;
  bit pend[N];
  logic [W-1:0] ox[N], oy[N];
  bit oc[N];
  int ops = 0;
  int gcnt[N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_x[i*W +: W] = ox[i];
      req_y[i*W +: W] = oy[i];
      req_cin[i] = oc[i];
    end
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    int g = pick();
    if (!busy && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic req(int i, logic [W-1:0] x, logic [W-1:0] y, bit c);
    pend[i] = 1; ox[i] = x; oy[i] = y; oc[i] = c;
    drive();
  endtask

  function automatic void model_reset();
    exp_q.delete();
    busy = 0; ptr = 0; ops = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; gcnt[i] = 0; end
  endfunction

  task automatic step(int p_req, int p_rdy);
    int g, s;
    rsp_t e;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready()));
    chk("rsp_valid", 64'(rsp_valid), 64'(busy));
    @(posedge clk);
    if (busy) begin
      if (rsp_ready) busy = 0;
    end else begin
      g = pick();
      if (g >= 0) begin
        s = int'(ox[g]) + int'(oy[g]) + int'(oc[g]);
        e.id = IDW'(g);
        e.sum = S'(s);
        e.zero = (s == 0);
        exp_q.push_back(e);
        ptr = (g + 1) % N;
        busy = 1;
        pend[g] = 0;
        ops++;
        gcnt[g]++;
      end
    end
    #1;
    for (int i = 0; i < N; i++)
      if (!pend[i] && $urandom_range(99) < p_req) begin
        pend[i] = 1;
        ox[i] = W'($urandom);
        oy[i] = W'($urandom);
        oc[i] = 1'($urandom);
      end
    rsp_ready = ($urandom_range(99) < p_rdy);
    drive();
  endtask

  // Monitor: compare any presented response against the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        chk("rsp_sum", 64'(rsp_sum), 64'(exp_q[0].sum));
        chk("rsp_zero", 64'(rsp_zero), 64'(exp_q[0].zero));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    rsp_ready = 1'b0;
    drive();
    rst_n = 1'b0;
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("reset_rsp_id", 64'(rsp_id), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(0, 100);

    req(1, 8'h12, 8'h34, 1'b1);
    step(0, 100);
    step(0, 100);

    req(0, 8'hFF, 8'hFF, 1'b1);
    step(0, 100);
    step(0, 100);
    req(2, 8'h00, 8'h00, 1'b0);
    step(0, 100);
    step(0, 100);

    req(3, 8'h80, 8'h7F, 1'b0);
    step(0, 0);
    for (int i = 0; i < 5; i++) step(0, 0);
    rsp_ready = 1'b1;
    req(0, 8'h01, 8'h02, 1'b0);
    step(0, 100);
    step(0, 100);
    step(0, 100);

    for (int i = 0; i < N; i++) req(i, W'($urandom), W'($urandom), 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) step(100, 100);

    for (int i = 0; i < 400; i++) step(40, 70);

    for (int i = 0; i < 8; i++) step(0, 100);
    req(1, 8'h05, 8'h06, 1'b0);
    step(0, 0);
    step(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midreset_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) req(i, W'(i), W'(i), 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) step(100, 100);

    for (int i = 0; i < 300; i++) step(50, 50);

    for (int i = 0; i < 12; i++) step(0, 100);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

`ifdef ADDER_SHARE_ARB_STATS_EN
    chk("op_cnt", 64'(op_cnt), 64'(ops > 65535 ? 65535 : ops));
    for (int i = 0; i < N; i++)
      chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(gcnt[i]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
